moxie_trace_buffer: RTL and testbench
=====================================

// Module: moxie_trace_buffer
// PURPOSE
//  Parametrised instruction-trace capture unit for the moxie core, the successor to the simulation-only printer.
//  Each cycle it can take one retired instruction (pc, opcode, immediate word) and decode its length and class.
//  It stores the record in a DEPTH-entry trace FIFO, which a debug port drains with a valid/ready handshake.
//  Adds trigger-on-PC start, stop/freeze, selectable overflow policy and a dropped-record counter.
// PARAMETERS
//  AW        32  pc width in bits
//  DEPTH     16  FIFO entries; power of two, >= 2
//  OVERWRITE 0   0: drop new record when full; 1: discard oldest, keep new
// PORTS
//  clk_i        in   1      clock, all logic on rising edge
//  rst_i        in   1      synchronous reset, active-low
//  valid_i      in   1      retired instruction present this cycle
//  pc_i         in   AW     pc of retired instruction
//  insn_i       in   16     opcode halfword
//  data_i       in   32     trailing immediate word (meaningful for 6-byte insns only)
//  enable_i     in   1      capture enable
//  trig_en_i    in   1      1: wait for pc_i==trig_pc_i before capturing
//  trig_pc_i    in   AW     trigger pc
//  stop_i       in   1      freeze capture
//  clear_i      in   1      flush FIFO, clear drop count, re-arm
//  t_valid_o    out  1      head record available
//  t_ready_i    in   1      consumer accepts head record
//  t_pc_o       out  AW     head record pc
//  t_insn_o     out  16     head record opcode
//  t_data_o     out  32     head record immediate; 0 for 2-byte insns
//  t_len_o      out  3      head record length in bytes: 2 or 6
//  t_class_o    out  2      0 form1, 1 form2, 2 branch, 3 bad
//  count_o      out  $clog2(DEPTH)+1  records held
//  drop_cnt_o   out  16     records lost, saturating at 16'hFFFF
//  state_o      out  2      0 ARMED, 1 RUN, 2 FREEZE
// BEHAVIOUR
//  Reset (rst_i==0 at edge): FIFO empty, t_valid_o=0, count_o=0, drop_cnt_o=0, state ARMED.
//    All t_* data outputs are 0 while t_valid_o=0.
//  Decode, op=insn_i[15:8]:
//    len=6 for op in {01,03,08,09,0C,0D,1A,1B,1D,1F,20,22,24,30,36,37,38,39}; otherwise len=2.
//    class=0 for op<=3F, excluding bad; class=1 for insn_i[15:14]=10; class=2 for insn_i[15:10]<=111001 with [15:14]=11.
//    class=3 (bad) for op 0F-18, 3A-7F, and insn_i[15:10]>=111010.
//    Bad records are stored with len=2.
//  FSM:
//    ARMED->RUN when enable_i && (!trig_en_i || (valid_i && pc_i==trig_pc_i)).
//      When the trigger is met, the triggering insn is itself captured in the same cycle.
//    RUN->FREEZE on stop_i. RUN->ARMED when enable_i falls; FIFO contents are kept.
//    FREEZE->ARMED only on clear_i.
//    clear_i in any state: flush FIFO, zero drop_cnt_o, go to ARMED; clear_i has priority over every other input.
//  Push = valid_i && (state RUN, or the ARMED->RUN trigger cycle) && !stop_i.
//    A stop_i cycle pushes nothing.
//  Pop = t_valid_o && t_ready_i.
//  Latency: a pushed record appears on t_* the cycle after the push edge. Head is first-word-fall-through.
//  Full, OVERWRITE=0: push is discarded; drop_cnt_o += 1. Pop still proceeds.
//  Full, OVERWRITE=1: oldest record is discarded and the new one written; drop_cnt_o += 1; count_o stays DEPTH.
//  Push and pop in the same cycle when full: pop takes the head and push is written.
//    No drop; count_o is unchanged; this holds under both policies.
//  Push and pop in the same cycle when empty: no bypass. The record is written and becomes visible next cycle.
//  Pointers wrap modulo DEPTH. count_o is exact from 0 to DEPTH.
//  drop_cnt_o holds at FFFF once saturated.
//  Reset asserted mid-drain: the head is lost, t_valid_o=0 next cycle, state returns to ARMED.
// TESTING
//  Reset, enable_i=1, trig_en_i=0; push insn 0x0123 data 0xDEADBEEF pc 0x100
//    -> next cycle t_valid_o=1, t_len_o=6, t_class_o=0, t_data_o=DEADBEEF.
//  trig_pc_i=0x200, trig_en_i=1; push pcs 0x1FC, 0x200, 0x202
//    -> count_o=2; first record pc 0x200; state_o goes 0->1.
//  OVERWRITE=0, DEPTH=4, t_ready_i=0; push 6 records
//    -> count_o=4, drop_cnt_o=2, head is record 1.
//  OVERWRITE=1, same stimulus -> count_o=4, drop_cnt_o=2, head is record 3.
//  Full FIFO with push+pop every cycle for 8 cycles -> drop_cnt_o=0, count_o=4.
//    Also check pointer wrap and record ordering.
//  Decode sweep: 0x0F00 -> class 3, len 2; 0x8312 -> class 1; 0xE400 -> class 2; 0xEC00 -> class 3.
//    Then stop_i -> state FREEZE and no further pushes; clear_i -> count_o=0, state ARMED.

Source files
------------

// File: rtl/moxie_trace_buffer.sv
// Purpose: instruction-trace capture for the moxie core; decodes retired insns and queues them for a debug port.
// Latency: a record pushed on edge N is visible on t_* after edge N (FWFT head, no empty-FIFO bypass).
// Backpressure: t_valid_o/t_ready_i handshake; when full, new records are dropped or the oldest is evicted (OVERWRITE).
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-low reset
//   valid_i, pc_i, insn_i, data_i retired instruction stream
//   enable_i, trig_en_i, trig_pc_i capture enable and pc trigger
//   stop_i, clear_i               freeze capture / flush, zero drop count and re-arm
//   t_valid_o, t_ready_i, t_*     head record and drain handshake (data fields zero while not valid)
//   count_o, drop_cnt_o, state_o  occupancy, saturating lost-record count, 0 ARMED / 1 RUN / 2 FREEZE

module moxie_trace_buffer #(
    parameter int AW        = 32,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic [AW-1:0]            pc_i,
    input  logic [15:0]              insn_i,
    input  logic [31:0]              data_i,
    input  logic                     enable_i,
    input  logic                     trig_en_i,
    input  logic [AW-1:0]            trig_pc_i,
    input  logic                     stop_i,
    input  logic                     clear_i,
    output logic                     t_valid_o,
    input  logic                     t_ready_i,
    output logic [AW-1:0]            t_pc_o,
    output logic [15:0]              t_insn_o,
    output logic [31:0]              t_data_o,
    output logic [2:0]               t_len_o,
    output logic [1:0]               t_class_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [15:0]              drop_cnt_o,
    output logic [1:0]               state_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_RUN    = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [15:0]   insn;
        logic [31:0]   data;
        logic [2:0]    len;
        logic [1:0]    cls;
    } rec_t;

    state_t        state, state_nxt;
    rec_t          mem [DEPTH];
    rec_t          new_rec;
    rec_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [15:0]   drop_cnt;

    logic [7:0]    op;
    logic          dec_bad, dec_long;
    logic          push, pop, full, wr_en, rd_adv, drop_inc, trig_hit;

    // ---------------- decode ----------------
    always_comb begin
        op       = insn_i[15:8];
        dec_bad  = (op >= 8'h0F && op <= 8'h18) || (op >= 8'h3A && op <= 8'h7F)
                   || (insn_i[15:10] >= 6'b111010);
        dec_long = 1'b0;
        case (op)
            8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
            8'h1F, 8'h20, 8'h22, 8'h24, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39:
                dec_long = 1'b1;
            default: dec_long = 1'b0;
        endcase
        // bad opcodes are never long, so the immediate is not kept for them
        dec_long = dec_long && !dec_bad;

        new_rec.pc   = pc_i;
        new_rec.insn = insn_i;
        new_rec.data = dec_long ? data_i : 32'd0;
        new_rec.len  = dec_long ? 3'd6 : 3'd2;
        if (dec_bad)
            new_rec.cls = 2'd3;
        else if (op <= 8'h3F)
            new_rec.cls = 2'd0;
        else if (insn_i[15:14] == 2'b10)
            new_rec.cls = 2'd1;
        else
            new_rec.cls = 2'd2;
    end

    // ---------------- capture FSM ----------------
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        trig_hit  = enable_i && (!trig_en_i || (valid_i && pc_i == trig_pc_i));
        if (clear_i) begin
            state_nxt = ST_ARMED;
        end else begin
            case (state)
                ST_ARMED: begin
                    // the triggering instruction is captured on the same edge
                    if (trig_hit) begin
                        state_nxt = ST_RUN;
                        push      = valid_i && !stop_i;
                    end
                end
                ST_RUN: begin
                    push = valid_i && !stop_i;
                    if (stop_i)
                        state_nxt = ST_FREEZE;
                    else if (!enable_i)
                        state_nxt = ST_ARMED;
                end
                ST_FREEZE: state_nxt = ST_FREEZE;
                default:   state_nxt = ST_ARMED;
            endcase
        end
    end

    // ---------------- FIFO control ----------------
    always_comb begin
        full     = (count == FULL_CNT);
        pop      = t_valid_o && t_ready_i;
        // full with a simultaneous pop is not an overflow: the popped slot takes the new record
        wr_en    = push && (!full || pop || OVERWRITE != 0);
        rd_adv   = pop || (push && full && (OVERWRITE != 0));
        drop_inc = push && full && !pop;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i || clear_i) begin
            state    <= ST_ARMED;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_adv)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_adv)
                count <= count + 1'b1;
            else if (!wr_en && rd_adv)
                count <= count - 1'b1;
            if (drop_inc && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // storage needs no reset; validity comes from count
    always_ff @(posedge clk_i) begin
        if (rst_i && !clear_i && wr_en)
            mem[wr_ptr] <= new_rec;
    end

    // ---------------- outputs ----------------
    always_comb begin
        head       = mem[rd_ptr];
        t_valid_o  = (count != '0);
        t_pc_o     = t_valid_o ? head.pc   : '0;
        t_insn_o   = t_valid_o ? head.insn : 16'd0;
        t_data_o   = t_valid_o ? head.data : 32'd0;
        t_len_o    = t_valid_o ? head.len  : 3'd0;
        t_class_o  = t_valid_o ? head.cls  : 2'd0;
        count_o    = count;
        drop_cnt_o = drop_cnt;
        state_o    = state;
    end

endmodule

// File: tb/tb_moxie_trace_buffer.sv
// Purpose: checks moxie_trace_buffer (DEPTH=4, both overflow policies side by side) against a queue model.
// Latency: model is advanced once per clock and compared 1 time unit after each rising edge.
// Backpressure: t_ready_i is driven directly by the stimulus (held low to fill, random during the soak).

module tb_moxie_trace_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] insn;
        logic [31:0] data;
        logic [2:0]  len;
        logic [1:0]  cls;
    } rec_t;

    logic        clk;
    logic        rst, valid, enable, trig_en, stop, clear, ready;
    logic [31:0] pc, trig_pc, data;
    logic [15:0] insn;

    logic        tv   [2];
    logic [31:0] tpc  [2];
    logic [15:0] tins [2];
    logic [31:0] tdat [2];
    logic [2:0]  tlen [2];
    logic [1:0]  tcls [2];
    logic [2:0]  cnt  [2];
    logic [15:0] drp  [2];
    logic [1:0]  st   [2];

    int errors = 0;
    int checks = 0;

    rec_t mq [2][$];
    int   mdrop [2];
    int   mstate;

    moxie_trace_buffer #(.AW(32), .DEPTH(DEPTH), .OVERWRITE(0)) u_drop (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .pc_i(pc), .insn_i(insn), .data_i(data),
        .enable_i(enable), .trig_en_i(trig_en), .trig_pc_i(trig_pc), .stop_i(stop), .clear_i(clear),
        .t_valid_o(tv[0]), .t_ready_i(ready), .t_pc_o(tpc[0]), .t_insn_o(tins[0]), .t_data_o(tdat[0]),
        .t_len_o(tlen[0]), .t_class_o(tcls[0]), .count_o(cnt[0]), .drop_cnt_o(drp[0]), .state_o(st[0])
    );

    moxie_trace_buffer #(.AW(32), .DEPTH(DEPTH), .OVERWRITE(1)) u_ovw (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .pc_i(pc), .insn_i(insn), .data_i(data),
        .enable_i(enable), .trig_en_i(trig_en), .trig_pc_i(trig_pc), .stop_i(stop), .clear_i(clear),
        .t_valid_o(tv[1]), .t_ready_i(ready), .t_pc_o(tpc[1]), .t_insn_o(tins[1]), .t_data_o(tdat[1]),
        .t_len_o(tlen[1]), .t_class_o(tcls[1]), .count_o(cnt[1]), .drop_cnt_o(drp[1]), .state_o(st[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // decode straight from the opcode-map rules
    function automatic rec_t mk(input logic [31:0] p, input logic [15:0] i, input logic [31:0] d);
        rec_t r;
        int   o;
        bit   bad;
        o   = int'(i[15:8]);
        bad = (o >= 'h0F && o <= 'h18) || (o >= 'h3A && o <= 'h7F) || (int'(i[15:10]) >= 'b111010);
        r.pc   = p;
        r.insn = i;
        if (bad)               r.cls = 2'd3;
        else if (o <= 'h3F)    r.cls = 2'd0;
        else if (i[15:14] == 2'b10) r.cls = 2'd1;
        else                   r.cls = 2'd2;
        if (!bad && (o inside {'h01,'h03,'h08,'h09,'h0C,'h0D,'h1A,'h1B,'h1D,'h1F,
                               'h20,'h22,'h24,'h30,'h36,'h37,'h38,'h39})) begin
            r.len  = 3'd6;
            r.data = d;
        end else begin
            r.len  = 3'd2;
            r.data = 32'd0;
        end
        return r;
    endfunction

    // advance the reference by one clock using the inputs currently applied
    task automatic model_step();
        bit do_push;
        rec_t r;
        if (!rst || clear) begin
            for (int k = 0; k < 2; k++) begin
                mq[k].delete();
                mdrop[k] = 0;
            end
            mstate = 0;
            return;
        end
        do_push = 0;
        if (mstate == 0) begin
            if (enable && (!trig_en || (valid && pc == trig_pc))) begin
                mstate  = 1;
                do_push = valid && !stop;
            end
        end else if (mstate == 1) begin
            do_push = valid && !stop;
            if (stop) mstate = 2;
            else if (!enable) mstate = 0;
        end
        r = mk(pc, insn, data);
        for (int k = 0; k < 2; k++) begin
            if (mq[k].size() > 0 && ready) void'(mq[k].pop_front());
            if (do_push) begin
                if (mq[k].size() < DEPTH) begin
                    mq[k].push_back(r);
                end else begin
                    if (k == 1) begin
                        void'(mq[k].pop_front());
                        mq[k].push_back(r);
                    end
                    if (mdrop[k] < 'hFFFF) mdrop[k]++;
                end
            end
        end
    endtask

    task automatic compare_model();
        rec_t h;
        for (int k = 0; k < 2; k++) begin
            h = '{pc: 0, insn: 0, data: 0, len: 0, cls: 0};
            if (mq[k].size() > 0) h = mq[k][0];
            chk($sformatf("m%0d_valid", k), 64'(tv[k]), 64'(mq[k].size() > 0));
            chk($sformatf("m%0d_count", k), 64'(cnt[k]), 64'(mq[k].size()));
            chk($sformatf("m%0d_drop", k), 64'(drp[k]), 64'(mdrop[k]));
            chk($sformatf("m%0d_state", k), 64'(st[k]), 64'(mstate));
            chk($sformatf("m%0d_pc", k), 64'(tpc[k]), 64'(h.pc));
            chk($sformatf("m%0d_insn", k), 64'(tins[k]), 64'(h.insn));
            chk($sformatf("m%0d_data", k), 64'(tdat[k]), 64'(h.data));
            chk($sformatf("m%0d_len", k), 64'(tlen[k]), 64'(h.len));
            chk($sformatf("m%0d_class", k), 64'(tcls[k]), 64'(h.cls));
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic [15:0] i, input logic [31:0] d);
        valid = v;
        pc    = p;
        insn  = i;
        data  = d;
    endtask

    initial begin
        rst = 1'b0; valid = 1'b0; enable = 1'b0; trig_en = 1'b0; stop = 1'b0; clear = 1'b0;
        ready = 1'b0; pc = '0; trig_pc = '0; data = '0; insn = '0;
        mstate = 0;
        mdrop[0] = 0;
        mdrop[1] = 0;

        // reset state
        step(); step();
        chk("rst_valid", 64'(tv[0]), 0);
        chk("rst_count", 64'(cnt[0]), 0);
        chk("rst_drop", 64'(drp[1]), 0);
        chk("rst_state", 64'(st[0]), 0);

        // first capture straight out of reset
        rst = 1'b1; enable = 1'b1;
        drive(1, 32'h100, 16'h0123, 32'hDEADBEEF);
        step();
        drive(0, 0, 0, 0);
        chk("t1_valid", 64'(tv[0]), 1);
        chk("t1_len", 64'(tlen[0]), 6);
        chk("t1_class", 64'(tcls[0]), 0);
        chk("t1_data", 64'(tdat[0]), 64'hDEADBEEF);

        // trigger on pc 0x200
        clear = 1'b1; step(); clear = 1'b0;
        trig_en = 1'b1; trig_pc = 32'h200;
        drive(1, 32'h1FC, 16'h0000, 0); step();
        chk("trig_armed", 64'(st[0]), 0);
        drive(1, 32'h200, 16'h0000, 0); step();
        chk("trig_run", 64'(st[0]), 1);
        drive(1, 32'h202, 16'h0000, 0); step();
        drive(0, 0, 0, 0);
        chk("trig_count", 64'(cnt[0]), 2);
        chk("trig_head", 64'(tpc[0]), 64'h200);
        trig_en = 1'b0;

        // overflow: six records into a four-entry FIFO with no drain
        clear = 1'b1; step(); clear = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1, 32'h1000 + 32'(2 * k), 16'h8000 + 16'(k), 0);
            step();
        end
        drive(0, 0, 0, 0);
        chk("ovf0_count", 64'(cnt[0]), 4);
        chk("ovf0_drop", 64'(drp[0]), 2);
        chk("ovf0_head", 64'(tpc[0]), 64'h1000);
        chk("ovf1_count", 64'(cnt[1]), 4);
        chk("ovf1_drop", 64'(drp[1]), 2);
        chk("ovf1_head", 64'(tpc[1]), 64'h1004);

        // full FIFO with push and pop every cycle: no drops, pointers wrap
        clear = 1'b1; step(); clear = 1'b0;
        for (int k = 0; k < 12; k++) begin
            ready = (k >= 4);
            drive(1, 32'h2000 + 32'(2 * k), 16'h0000, 0);
            step();
        end
        drive(0, 0, 0, 0); ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("pp%0d_drop", k), 64'(drp[k]), 0);
            chk($sformatf("pp%0d_count", k), 64'(cnt[k]), 4);
            chk($sformatf("pp%0d_head", k), 64'(tpc[k]), 64'h2010);
        end

        // decode sweep
        clear = 1'b1; step(); clear = 1'b0;
        drive(1, 32'h300, 16'h0F00, 32'h11111111); step();
        drive(1, 32'h302, 16'h8312, 32'h22222222); step();
        drive(1, 32'h304, 16'hE400, 32'h33333333); step();
        drive(1, 32'h306, 16'hEC00, 32'h44444444); step();
        drive(0, 0, 0, 0);
        chk("dec0_class", 64'(tcls[0]), 3);
        chk("dec0_len", 64'(tlen[0]), 2);
        ready = 1'b1; step(); ready = 1'b0;
        chk("dec1_class", 64'(tcls[0]), 1);
        ready = 1'b1; step(); ready = 1'b0;
        chk("dec2_class", 64'(tcls[0]), 2);
        ready = 1'b1; step(); ready = 1'b0;
        chk("dec3_class", 64'(tcls[0]), 3);
        chk("dec3_data", 64'(tdat[0]), 0);
        ready = 1'b1; step(); ready = 1'b0;

        // stop freezes capture, clear re-arms and flushes
        drive(1, 32'h400, 16'h0000, 0); step();
        drive(1, 32'h402, 16'h0000, 0); step();
        stop = 1'b1;
        drive(1, 32'h404, 16'h0000, 0); step();
        stop = 1'b0;
        chk("stop_state", 64'(st[0]), 2);
        chk("stop_count", 64'(cnt[0]), 2);
        step(); step();
        chk("frz_count", 64'(cnt[0]), 2);
        drive(0, 0, 0, 0);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_count", 64'(cnt[0]), 0);
        chk("clr_state", 64'(st[0]), 0);

        // reset in the middle of a drain
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h500 + 32'(2 * k), 16'h0000, 0);
            step();
        end
        drive(0, 0, 0, 0); ready = 1'b1; step();
        rst = 1'b0; step(); rst = 1'b1; ready = 1'b0;
        chk("rstd_valid", 64'(tv[0]), 0);
        chk("rstd_state", 64'(st[0]), 0);

        // randomized soak against the model
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 499) != 0);
            clear   = ($urandom_range(0, 99) == 0);
            stop    = ($urandom_range(0, 79) == 0);
            enable  = ($urandom_range(0, 19) != 0);
            trig_en = ($urandom_range(0, 3) == 0);
            trig_pc = 32'h40 + 32'(2 * $urandom_range(0, 1) * 2);
            ready   = ($urandom_range(0, 1) == 1);
            drive($urandom_range(0, 9) < 7, 32'h40 + 32'(2 * $urandom_range(0, 15)),
                  16'($urandom), $urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
